sprite_motion_ctrl: RTL

// Parametrised tile-aware motion controller for a maze sprite: pac-man now, ghosts via parameters.

---
 rtl/sprite_motion_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: tile-aware maze sprite mover with buffered turns,
// wall-legality queries over a req/ack port and horizontal tunnel wrap.
module sprite_motion_ctrl #(
    parameter int         XW        = 10,
    parameter int         YW        = 10,
    parameter int         INI_X     = 360,
    parameter int         INI_Y     = 154,
    parameter logic [3:0] INI_DIR   = 4'b0010,
    parameter int         SPEED     = 2,
    parameter int         TILE      = 8,
    parameter int         X_MIN     = 0,
    parameter int         X_MAX     = 632,
    parameter int         BUF_TICKS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          move_tick,
    input  logic [3:0]    dir_req,
    output logic          q_req,
    output logic [XW-1:0] q_x,
    output logic [YW-1:0] q_y,
    input  logic          q_ack,
    input  logic [3:0]    q_legal,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [3:0]    dir,
    output logic          moving,
    output logic          overrun
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_QUERY,
        S_DECIDE,
        S_STEP
    } state_t;

    localparam logic [XW-1:0] X0    = XW'(INI_X);
    localparam logic [YW-1:0] Y0    = YW'(INI_Y);
    localparam logic [XW-1:0] XLO   = XW'(X_MIN);
    localparam logic [XW-1:0] XHI   = XW'(X_MAX);
    localparam logic [XW-1:0] SPD_X = XW'(SPEED);
    localparam logic [YW-1:0] SPD_Y = YW'(SPEED);
    localparam logic [XW-1:0] MSK_X = XW'(TILE - 1);
    localparam logic [YW-1:0] MSK_Y = YW'(TILE - 1);
    localparam logic [7:0]    LIFE  = 8'(BUF_TICKS);

    state_t        state_q;
    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [YW-1:0] pos_y_q, pos_y_d;
    logic [3:0]    dir_q;
    logic [3:0]    pend_q, pend_d;
    logic [7:0]    life_q, life_d;
    logic [3:0]    legal_q;
    logic          allow_q;
    logic          moving_q;
    logic          q_req_q;
    logic          overrun_q;

    logic [XW-1:0] off_x;
    logic [YW-1:0] off_y;
    logic          aligned;
    logic [3:0]    pick;
    logic [3:0]    opp_dir;
    logic          pend_opp;
    logic          take;
    logic [3:0]    dir_sel;
    logic          allow;

    // The tile grid is anchored at the reset position.
    assign off_x   = pos_x_q - X0;
    assign off_y   = pos_y_q - Y0;
    assign aligned = ((off_x & MSK_X) == '0)
                  && ((off_y & MSK_Y) == '0);

    always_comb begin
        pick = 4'b0000;
        if (dir_req[3])      pick = 4'b1000;
        else if (dir_req[2]) pick = 4'b0100;
        else if (dir_req[1]) pick = 4'b0010;
        else if (dir_req[0]) pick = 4'b0001;
    end

    assign opp_dir  = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
    assign pend_opp = (pend_q != 4'b0000) && (pend_q == opp_dir);
    assign take     = pend_opp || (aligned && |(pend_q & legal_q));
    assign dir_sel  = take ? pend_q : dir_q;
    assign allow    = !aligned || |(dir_sel & legal_q);

    always_comb begin
        pend_d = pend_q;
        life_d = life_q;
        if (dir_req != 4'b0000) begin
            pend_d = pick;
            life_d = LIFE;
        end else begin
            if (move_tick && life_q != 8'd0) begin
                life_d = life_q - 8'd1;
                if (life_q == 8'd1) pend_d = 4'b0000;
            end
            if (state_q == S_DECIDE && take) begin
                pend_d = 4'b0000;
                life_d = 8'd0;
            end
        end
    end

    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        unique case (1'b1)
            dir_q[3]: pos_y_d = pos_y_q - SPD_Y;
            dir_q[2]: pos_y_d = pos_y_q + SPD_Y;
            dir_q[1]: pos_x_d = (pos_x_q == XLO) ? XHI
                                                 : pos_x_q - SPD_X;
            dir_q[0]: pos_x_d = (pos_x_q == XHI) ? XLO
                                                 : pos_x_q + SPD_X;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pos_x_q   <= X0;
            pos_y_q   <= Y0;
            dir_q     <= INI_DIR;
            pend_q    <= 4'b0000;
            life_q    <= 8'd0;
            legal_q   <= 4'b0000;
            allow_q   <= 1'b0;
            moving_q  <= 1'b0;
            q_req_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            life_q    <= life_d;
            overrun_q <= move_tick && (state_q != S_IDLE);
            unique case (state_q)
                S_IDLE: begin
                    if (move_tick) begin
                        state_q <= S_QUERY;
                        q_req_q <= 1'b1;
                    end
                end
                S_QUERY: begin
                    if (q_ack) begin
                        legal_q <= q_legal;
                        q_req_q <= 1'b0;
                        state_q <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    dir_q   <= dir_sel;
                    allow_q <= allow;
                    state_q <= S_STEP;
                end
                S_STEP: begin
                    if (allow_q) begin
                        pos_x_q <= pos_x_d;
                        pos_y_q <= pos_y_d;
                    end
                    moving_q <= allow_q;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign q_req   = q_req_q;
    assign q_x     = pos_x_q;
    assign q_y     = pos_y_q;
    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;
    assign dir     = dir_q;
    assign moving  = moving_q;
    assign overrun = overrun_q;

endmodule
